// File: rtl/score_matrix_ctrl.sv
// score_matrix_ctrl: Needleman-Wunsch score-matrix manager.
// Owns the (N+1)x(M+1) score RAM (addr = i*(M+1)+j), writes the gap-penalty
// boundary row/column on start, serves diag/up/left fetches to the PE and
// collects the PE write-backs, flagging completion when (N,M) is written.
// Optional traceback read port is enabled by defining TRACE_PORT_EN.
module score_matrix_ctrl #(
    parameter int unsigned N   = 128,
    parameter int unsigned M   = 128,
    parameter int unsigned W   = 9,
    parameter int          GAP = -2,
    parameter int unsigned IW  = $clog2(((N > M) ? N : M) + 1),
    parameter int unsigned AW  = $clog2((N + 1) * (M + 1))
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [IW-1:0]       i_i,
    input  logic [IW-1:0]       j_i,
    input  logic                fetch_req_i,
    output logic                fetch_ack_o,
    output logic                fetch_valid_o,
    output logic signed [W-1:0] diag_o,
    output logic signed [W-1:0] up_o,
    output logic signed [W-1:0] left_o,
    input  logic                wr_en_i,
    input  logic signed [W-1:0] wr_data_i,
`ifdef TRACE_PORT_EN
    input  logic                tb_req_i,
    input  logic [IW-1:0]       tb_i_i,
    input  logic [IW-1:0]       tb_j_i,
    output logic signed [W-1:0] tb_score_o,
    output logic                tb_valid_o,
`endif
    output logic                ready_o,
    output logic                init_done_o,
    output logic                err_o,
    output logic                matrix_done_o,
    output logic signed [W-1:0] final_score_o
);

    localparam int unsigned     CW     = $clog2(N + M + 1);
    localparam int unsigned     DEPTH  = (N + 1) * (M + 1);
    localparam logic signed [W:0] SAT_HI = (W+1)'((2 ** (W - 1)) - 1);
    localparam logic signed [W:0] SAT_LO = (W+1)'(-(2 ** (W - 1)));
    localparam logic signed [W:0] GAP_X  = (W+1)'(GAP);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_READY, S_FETCH} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [W-1:0]   acc_q, acc_d;
    logic [1:0]            ph_q, ph_d;
    logic [IW-1:0]         fi_q, fi_d, fj_q, fj_d;
    logic signed [W-1:0]   sh_diag_q, sh_diag_d, sh_up_q, sh_up_d;
    logic signed [W-1:0]   diag_q, diag_d, up_q, up_d, left_q, left_d;
    logic signed [W-1:0]   final_q, final_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d, valid_q, valid_d;
    logic                  ready_q, ready_d, init_done_q, init_done_d, err_q, err_d;
`ifdef TRACE_PORT_EN
    logic                  tb_pend_q, tb_pend_d, tb_valid_q, tb_valid_d;
    logic signed [W-1:0]   tb_score_q, tb_score_d;
`endif

    logic                  we_c, re_c, idx_ok_c;
    logic [AW-1:0]         waddr_c, raddr_c;
    logic signed [W-1:0]   wdata_c;
    logic signed [W-1:0]   mem_q [DEPTH];
    logic signed [W-1:0]   rd_q;

    // Next boundary value: add GAP with clamping instead of wrap-around.
    function automatic logic signed [W-1:0] sat_step(input logic signed [W-1:0] a);
        logic signed [W:0] s;
        s = $signed({a[W-1], a}) + GAP_X;
        if (s > SAT_HI)      sat_step = SAT_HI[W-1:0];
        else if (s < SAT_LO) sat_step = SAT_LO[W-1:0];
        else                 sat_step = s[W-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [IW-1:0] r, input logic [IW-1:0] c);
        cell_addr = AW'(r) * AW'(M + 1) + AW'(c);
    endfunction

    assign idx_ok_c = (i_i != '0) && (i_i <= IW'(N)) && (j_i != '0) && (j_i <= IW'(M));

    // Next-state, RAM control and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ph_d        = ph_q;
        fi_d        = fi_q;
        fj_d        = fj_q;
        sh_diag_d   = sh_diag_q;
        sh_up_d     = sh_up_q;
        diag_d      = diag_q;
        up_d        = up_q;
        left_d      = left_q;
        final_d     = final_q;
        done_d      = done_q;
        ack_d       = 1'b0;
        valid_d     = 1'b0;
        init_done_d = 1'b0;
        err_d       = 1'b0;
        we_c        = 1'b0;
        waddr_c     = '0;
        wdata_c     = '0;
        re_c        = 1'b0;
        raddr_c     = '0;
`ifdef TRACE_PORT_EN
        tb_pend_d   = 1'b0;
        tb_valid_d  = 1'b0;
        tb_score_d  = tb_score_q;
        if (tb_pend_q) begin
            tb_valid_d = 1'b1;
            tb_score_d = rd_q;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    acc_d   = '0;
                    done_d  = 1'b0;
                    final_d = '0;
                end
            end
            S_INIT: begin
                we_c  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == '0) begin
                    waddr_c = '0;
                    wdata_c = '0;
                    acc_d   = sat_step('0);
                end else if (cnt_q <= CW'(N)) begin
                    waddr_c = cell_addr(IW'(cnt_q), '0);
                    wdata_c = acc_q;
                    acc_d   = (cnt_q == CW'(N)) ? sat_step('0) : sat_step(acc_q);
                end else begin
                    waddr_c = cell_addr('0, IW'(cnt_q - CW'(N)));
                    wdata_c = acc_q;
                    acc_d   = sat_step(acc_q);
                end
                if (cnt_q == CW'(N + M)) begin
                    state_d     = S_READY;
                    init_done_d = 1'b1;
                end
            end
            S_READY: begin
                if (start_i) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    acc_d   = '0;
                    done_d  = 1'b0;
                    final_d = '0;
                end else if (wr_en_i) begin
                    if (idx_ok_c) begin
                        we_c    = 1'b1;
                        waddr_c = cell_addr(i_i, j_i);
                        wdata_c = wr_data_i;
                        if ((i_i == IW'(N)) && (j_i == IW'(M))) begin
                            done_d  = 1'b1;
                            final_d = wr_data_i;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (fetch_req_i) begin
                    if (idx_ok_c) begin
                        state_d = S_FETCH;
                        ack_d   = 1'b1;
                        fi_d    = i_i;
                        fj_d    = j_i;
                        ph_d    = '0;
                        re_c    = 1'b1;
                        raddr_c = cell_addr(i_i - IW'(1), j_i - IW'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
`ifdef TRACE_PORT_EN
                else if (tb_req_i && !tb_pend_q && !tb_valid_q) begin
                    if ((tb_i_i <= IW'(N)) && (tb_j_i <= IW'(M))) begin
                        re_c      = 1'b1;
                        raddr_c   = cell_addr(tb_i_i, tb_j_i);
                        tb_pend_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
            end
            S_FETCH: begin
                case (ph_q)
                    2'd0: begin
                        re_c      = 1'b1;
                        raddr_c   = cell_addr(fi_q - IW'(1), fj_q);
                        sh_diag_d = rd_q;
                        ph_d      = 2'd1;
                    end
                    2'd1: begin
                        re_c    = 1'b1;
                        raddr_c = cell_addr(fi_q, fj_q - IW'(1));
                        sh_up_d = rd_q;
                        ph_d    = 2'd2;
                    end
                    default: begin
                        diag_d  = sh_diag_q;
                        up_d    = sh_up_q;
                        left_d  = rd_q;
                        valid_d = 1'b1;
                        state_d = S_READY;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_READY);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ph_q        <= '0;
            fi_q        <= '0;
            fj_q        <= '0;
            sh_diag_q   <= '0;
            sh_up_q     <= '0;
            diag_q      <= '0;
            up_q        <= '0;
            left_q      <= '0;
            final_q     <= '0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef TRACE_PORT_EN
            tb_pend_q   <= 1'b0;
            tb_valid_q  <= 1'b0;
            tb_score_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ph_q        <= ph_d;
            fi_q        <= fi_d;
            fj_q        <= fj_d;
            sh_diag_q   <= sh_diag_d;
            sh_up_q     <= sh_up_d;
            diag_q      <= diag_d;
            up_q        <= up_d;
            left_q      <= left_d;
            final_q     <= final_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
`ifdef TRACE_PORT_EN
            tb_pend_q   <= tb_pend_d;
            tb_valid_q  <= tb_valid_d;
            tb_score_q  <= tb_score_d;
`endif
        end
    end

    // Score RAM: one write port, one registered read port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_c) mem_q[waddr_c] <= wdata_c;
        if (re_c) rd_q <= mem_q[raddr_c];
    end

    assign fetch_ack_o   = ack_q;
    assign fetch_valid_o = valid_q;
    assign diag_o        = diag_q;
    assign up_o          = up_q;
    assign left_o        = left_q;
    assign ready_o       = ready_q;
    assign init_done_o   = init_done_q;
    assign err_o         = err_q;
    assign matrix_done_o = done_q;
    assign final_score_o = final_q;
`ifdef TRACE_PORT_EN
    assign tb_score_o    = tb_score_q;
    assign tb_valid_o    = tb_valid_q;
`endif

endmodule

// File: tb/tb_score_matrix_ctrl.sv
// tb_score_matrix_ctrl: self-checking bench for score_matrix_ctrl.
// Main instance N=4 M=3 W=9 GAP=-2; second instance W=4 GAP=-3 for clamping.
`timescale 1ns/1ps
module tb_score_matrix_ctrl;
    localparam int N    = 4;
    localparam int M    = 3;
    localparam int W    = 9;
    localparam int GAP  = -2;
    localparam int SW   = 4;
    localparam int SGAP = -3;
    localparam int IW   = 3;

    logic clk;
    logic rst_n;
    logic start, fetch_req, wr_en;
    logic [IW-1:0] ci, cj;
    logic signed [W-1:0] wr_data;
    logic fetch_ack, fetch_valid, ready, init_done, err, matrix_done;
    logic signed [W-1:0] diag, up, left, final_score;

    logic s_start, s_fetch_req, s_wr_en;
    logic [IW-1:0] s_ci, s_cj;
    logic signed [SW-1:0] s_wr_data;
    logic s_fetch_ack, s_fetch_valid, s_ready, s_init_done, s_err, s_matrix_done;
    logic signed [SW-1:0] s_diag, s_up, s_left, s_final_score;
`ifdef TRACE_PORT_EN
    logic tb_req, tb_valid, s_tb_req, s_tb_valid;
    logic [IW-1:0] tb_i, tb_j, s_tb_i, s_tb_j;
    logic signed [W-1:0] tb_score;
    logic signed [SW-1:0] s_tb_score;
`endif

    int checks = 0;
    int errors = 0;
    int mdl [0:N][0:M];

    typedef struct {
        bit wr; int i; int j; int d; bit e; int ed; int eu; int el;
    } vec_t;
    vec_t vt [12];

    score_matrix_ctrl #(.N(N), .M(M), .W(W), .GAP(GAP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .i_i(ci), .j_i(cj),
        .fetch_req_i(fetch_req), .fetch_ack_o(fetch_ack), .fetch_valid_o(fetch_valid),
        .diag_o(diag), .up_o(up), .left_o(left), .wr_en_i(wr_en), .wr_data_i(wr_data),
`ifdef TRACE_PORT_EN
        .tb_req_i(tb_req), .tb_i_i(tb_i), .tb_j_i(tb_j), .tb_score_o(tb_score), .tb_valid_o(tb_valid),
`endif
        .ready_o(ready), .init_done_o(init_done), .err_o(err),
        .matrix_done_o(matrix_done), .final_score_o(final_score)
    );

    score_matrix_ctrl #(.N(N), .M(M), .W(SW), .GAP(SGAP)) sdut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .i_i(s_ci), .j_i(s_cj),
        .fetch_req_i(s_fetch_req), .fetch_ack_o(s_fetch_ack), .fetch_valid_o(s_fetch_valid),
        .diag_o(s_diag), .up_o(s_up), .left_o(s_left), .wr_en_i(s_wr_en), .wr_data_i(s_wr_data),
`ifdef TRACE_PORT_EN
        .tb_req_i(s_tb_req), .tb_i_i(s_tb_i), .tb_j_i(s_tb_j), .tb_score_o(s_tb_score), .tb_valid_o(s_tb_valid),
`endif
        .ready_o(s_ready), .init_done_o(s_init_done), .err_o(s_err),
        .matrix_done_o(s_matrix_done), .final_score_o(s_final_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampv(input int v, input int w);
        int lo, hi;
        lo = -(1 <<< (w - 1));
        hi = (1 <<< (w - 1)) - 1;
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_init();
        for (int r = 0; r <= N; r++) mdl[r][0] = clampv(r * GAP, W);
        for (int c = 0; c <= M; c++) mdl[0][c] = clampv(c * GAP, W);
    endtask

    task automatic do_init(input string nm);
        int n;
        start = 1'b1; s_start = 1'b1;
        step();
        start = 1'b0; s_start = 1'b0;
        check({nm, " done_cleared"}, int'(matrix_done), 0);
        check({nm, " final_cleared"}, int'(final_score), 0);
        n = 0;
        do begin step(); n++; end while (!init_done && n < 40);
        check({nm, " init_latency"}, n, N + M + 1);
        check({nm, " ready_at_done"}, int'(ready), 1);
        check({nm, " sat_init_done"}, int'(s_init_done), 1);
        step();
        check({nm, " init_done_pulse"}, int'(init_done), 0);
        model_init();
    endtask

    task automatic wr_chk(input int wi, input int wj, input int d, input bit exp_err, input string nm);
        ci = IW'(wi); cj = IW'(wj); wr_data = W'(d); wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        check({nm, " err"}, int'(err), int'(exp_err));
        if (!exp_err) mdl[wi][wj] = d;
    endtask

    task automatic fetch_chk(input int fi, input int fj, input int ed, input int eu, input int el, input string nm);
        int n;
        ci = IW'(fi); cj = IW'(fj); fetch_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!fetch_ack && n < 10);
        fetch_req = 1'b0;
        check({nm, " ack_latency"}, n, 1);
        check({nm, " ready_low"}, int'(ready), 0);
        n = 0;
        do begin step(); n++; end while (!fetch_valid && n < 10);
        check({nm, " valid_latency"}, n, 3);
        check({nm, " diag"}, int'(diag), ed);
        check({nm, " up"}, int'(up), eu);
        check({nm, " left"}, int'(left), el);
        check({nm, " ready_back"}, int'(ready), 1);
    endtask

    task automatic fetch_bad(input int fi, input int fj, input string nm);
        bit seen;
        ci = IW'(fi); cj = IW'(fj); fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check({nm, " err"}, int'(err), 1);
        seen = fetch_ack;
        repeat (4) begin
            step();
            if (fetch_ack || fetch_valid) seen = 1'b1;
        end
        check({nm, " no_ack_valid"}, int'(seen), 0);
    endtask

    task automatic s_fetch(input int fi, input int fj, input int ed, input int eu, input int el, input string nm);
        int n;
        s_ci = IW'(fi); s_cj = IW'(fj); s_fetch_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!s_fetch_ack && n < 10);
        s_fetch_req = 1'b0;
        check({nm, " ack_latency"}, n, 1);
        n = 0;
        do begin step(); n++; end while (!s_fetch_valid && n < 10);
        check({nm, " valid_latency"}, n, 3);
        check({nm, " diag"}, int'(s_diag), ed);
        check({nm, " up"}, int'(s_up), eu);
        check({nm, " left"}, int'(s_left), el);
    endtask

`ifdef TRACE_PORT_EN
    task automatic trace_chk(input int ti, input int tj, input int exp, input string nm);
        int n;
        tb_i = IW'(ti); tb_j = IW'(tj); tb_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!tb_valid && n < 10);
        tb_req = 1'b0;
        check({nm, " latency"}, n, 2);
        check({nm, " score"}, int'(tb_score), exp);
    endtask
`endif

    initial begin
        int n, ri, rj, d;
        bit seen;
        rst_n = 1'b0;
        start = 1'b0; fetch_req = 1'b0; wr_en = 1'b0; ci = '0; cj = '0; wr_data = '0;
        s_start = 1'b0; s_fetch_req = 1'b0; s_wr_en = 1'b0; s_ci = '0; s_cj = '0; s_wr_data = '0;
`ifdef TRACE_PORT_EN
        tb_req = 1'b0; tb_i = '0; tb_j = '0; s_tb_req = 1'b0; s_tb_i = '0; s_tb_j = '0;
`endif
        for (int r = 0; r <= N; r++) for (int c = 0; c <= M; c++) mdl[r][c] = 0;

        // Table: hand-derived for N=4 M=3 GAP=-2 boundary.
        vt[0]  = '{1'b0, 1, 1, 0, 1'b0, 0, -2, -2};
        vt[1]  = '{1'b1, 1, 1, 1, 1'b0, 0, 0, 0};
        vt[2]  = '{1'b0, 1, 2, 0, 1'b0, -2, -4, 1};
        vt[3]  = '{1'b0, 0, 1, 0, 1'b1, 0, 0, 0};
        vt[4]  = '{1'b1, 5, 1, 3, 1'b1, 0, 0, 0};
        vt[5]  = '{1'b1, 2, 1, 4, 1'b0, 0, 0, 0};
        vt[6]  = '{1'b1, 1, 2, -1, 1'b0, 0, 0, 0};
        vt[7]  = '{1'b0, 2, 2, 0, 1'b0, 1, -1, 4};
        vt[8]  = '{1'b0, 4, 4, 0, 1'b1, 0, 0, 0};
        vt[9]  = '{1'b1, 0, 2, 9, 1'b1, 0, 0, 0};
        vt[10] = '{1'b0, 2, 1, 0, 1'b0, -2, 1, -4};
        vt[11] = '{1'b1, 4, 0, 1, 1'b1, 0, 0, 0};

        step(); step();
        check("reset ready", int'(ready), 0);
        check("reset init_done", int'(init_done), 0);
        check("reset matrix_done", int'(matrix_done), 0);
        check("reset final_score", int'(final_score), 0);
        check("reset diag", int'(diag), 0);
        check("reset fetch_valid", int'(fetch_valid), 0);
        rst_n = 1'b1;

        // IDLE: fetch and write are ignored silently.
        ci = 3'd1; cj = 3'd1; fetch_req = 1'b1; wr_en = 1'b0;
        seen = 1'b0;
        repeat (3) begin step(); if (fetch_ack || err || ready) seen = 1'b1; end
        fetch_req = 1'b0;
        check("idle ignores fetch", int'(seen), 0);

        do_init("init1");

        for (int k = 0; k < 12; k++) begin
            if (vt[k].wr) wr_chk(vt[k].i, vt[k].j, vt[k].d, vt[k].e, $sformatf("vec%0d", k));
            else if (vt[k].e) fetch_bad(vt[k].i, vt[k].j, $sformatf("vec%0d", k));
            else fetch_chk(vt[k].i, vt[k].j, vt[k].ed, vt[k].eu, vt[k].el, $sformatf("vec%0d", k));
        end

        // Simultaneous write and fetch: write wins, fetch accepted a cycle later.
        wr_chk(1, 3, 2, 1'b0, "pre_conflict");
        ci = 3'd2; cj = 3'd2; wr_data = W'(7); wr_en = 1'b1; fetch_req = 1'b1;
        step();
        wr_en = 1'b0;
        check("conflict no_early_ack", int'(fetch_ack), 0);
        mdl[2][2] = 7;
        n = 0;
        do begin step(); n++; end while (!fetch_ack && n < 10);
        fetch_req = 1'b0;
        check("conflict ack_delay", n, 1);
        n = 0;
        do begin step(); n++; end while (!fetch_valid && n < 10);
        check("conflict valid_latency", n, 3);
        check("conflict diag", int'(diag), mdl[1][1]);
        check("conflict up", int'(up), mdl[1][2]);
        check("conflict left", int'(left), mdl[2][1]);
        fetch_chk(2, 3, mdl[1][2], mdl[1][3], mdl[2][2], "post_conflict");

        // Clamped boundary on the narrow instance.
        s_ci = 3'd3; s_cj = 3'd1; s_wr_data = SW'(5); s_wr_en = 1'b1;
        step();
        s_wr_en = 1'b0;
        s_fetch(4, 1, clampv(3 * SGAP, SW), 5, clampv(4 * SGAP, SW), "sat41");
        s_fetch(1, 1, 0, clampv(SGAP, SW), clampv(SGAP, SW), "sat11");

        // Fill every interior cell except (N,M), then random traffic.
        for (int r = 1; r <= N; r++)
            for (int c = 1; c <= M; c++)
                if (!(r == N && c == M)) wr_chk(r, c, int'($urandom_range(0, 511)) - 256, 1'b0, "fill");
        for (int k = 0; k < 30; k++) begin
            ri = int'($urandom_range(0, 5));
            rj = int'($urandom_range(0, 4));
            if (ri == N && rj == M) rj = 1;
            if ($urandom_range(0, 1) == 1) begin
                d = int'($urandom_range(0, 511)) - 256;
                wr_chk(ri, rj, d, !(ri >= 1 && ri <= N && rj >= 1 && rj <= M), $sformatf("rnd_wr%0d", k));
            end else if (ri >= 1 && ri <= N && rj >= 1 && rj <= M) begin
                fetch_chk(ri, rj, mdl[ri-1][rj-1], mdl[ri-1][rj], mdl[ri][rj-1], $sformatf("rnd_fetch%0d", k));
            end else begin
                fetch_bad(ri, rj, $sformatf("rnd_bad%0d", k));
            end
        end

        // Completion.
        check("done before final write", int'(matrix_done), 0);
        wr_chk(N, M, 5, 1'b0, "final_wr");
        check("matrix_done set", int'(matrix_done), 1);
        check("final_score", int'(final_score), 5);
`ifdef TRACE_PORT_EN
        trace_chk(N, M, 5, "trace_nm");
        trace_chk(0, 2, mdl[0][2], "trace_02");
`endif
        do_init("init2");
        check("done after restart", int'(matrix_done), 0);
        fetch_chk(1, 2, mdl[0][1], mdl[0][2], mdl[1][1], "after_restart");

        // Reset mid-fetch aborts it.
        ci = 3'd1; cj = 3'd1; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("abort ack", int'(fetch_ack), 1);
        step();
        rst_n = 1'b0;
        #1;
        check("abort ready", int'(ready), 0);
        check("abort fetch_ack", int'(fetch_ack), 0);
        check("abort outputs", int'(diag | up | left | final_score), 0);
        check("abort flags", int'({fetch_valid, init_done, err, matrix_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin step(); if (fetch_valid || ready) seen = 1'b1; end
        check("abort no_valid", int'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
